uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Shares one 8N1 UART transmit line between two requesters: CPU UART store path on port 0, and debug/status dump on port 1.
- Round-robin arbitration between the two ports.
- Latches the granted byte and serialises it on tx.
- Bit timing comes from an internal 16x oversample tick derived from sysclk, so everything runs in one clock domain and no derived clocks are used.
- Sits between the peripheral bus and the board RX pin of the host serial link.

Parameters:
TICK_DIV, 328, sysclk cycles per oversample tick; must be >= 2.
OVERSAMPLE, 16, ticks per UART bit.
DATA_W, 8, data bits per frame.

Ports:
sysclk  in  1  system clock, all logic on posedge.
resetb  in  1  asynchronous active-low reset.
req0  in  1  port 0 transmit request, level; held until ack0.
data0  in  DATA_W  port 0 byte; stable while req0 is high and ack0 has not yet been seen.
ack0  out  1  one-cycle pulse when the port 0 byte is latched.
req1  in  1  port 1 transmit request, level.
data1  in  DATA_W  port 1 byte.
ack1  out  1  one-cycle pulse when the port 1 byte is latched.
tx  out  1  serial line; idles high.
busy  out  1  high while a frame is in progress.
grant_id  out  1  port owning the current/last frame.

Behaviour:
- Reset (async, resetb=0) drives these values immediately, including mid-frame:
  - tx=1, busy=0, ack0=ack1=0, grant_id=0.
  - state=IDLE, last_grant=1, so port 0 wins the first tie.
  - All counters cleared.
  - A partially sent frame is abandoned with no ack.
- State machine: IDLE -> START -> DATA -> STOP -> IDLE. All outputs are registered.
- IDLE arbitration, in a cycle N where any req is high:
  - Only one req high: grant that port.
  - Both high: grant the port != last_grant.
  - At edge N+1:
    - ackX=1 for exactly one cycle.
    - Shift register <= dataX; grant_id, last_grant <= X.
    - tx=0, busy=1, state=START.
    - Tick divider and tick count cleared.
- Tick generator: counter 0..TICK_DIV-1 and a one-cycle tick enable at terminal count. It is cleared synchronously on grant, so frame timing is exact.
- Bit period: OVERSAMPLE ticks = OVERSAMPLE*TICK_DIV cycles; a 4-bit tick counter counts the ticks within a bit.
- START: tx=0 for one bit period, then DATA.
- DATA:
  - DATA_W bits, LSB first; tx = shift[0].
  - Shift right at each bit boundary.
  - Bit index counter 0..DATA_W-1; after the last bit go to STOP.
- STOP: tx=1 for one bit period, then IDLE with busy=0.
- Frame length: (DATA_W+2)*OVERSAMPLE*TICK_DIV cycles, measured from the grant edge to the busy-fall edge. Default is 52480 cycles.
- Back-to-back: the earliest next grant is evaluated in the first IDLE cycle, so tx is high for exactly one cycle between the stop bit and the next start bit.
- req handling:
  - A req still high in the cycle after ack is ignored until IDLE.
  - A requester wanting a single byte drops req after ack.
  - A req that is held high is re-granted as a new byte.
  - Fairness: with both reqs held, grants alternate 0,1,0,1.
- During a frame: req and data changes are ignored; the latched byte is unaffected.
- ack is never asserted outside IDLE->START; ack0 and ack1 are never high together.

Decomposition:
- Shared package uart_pkg:
  - State enum (IDLE, START, DATA, STOP).
  - Frame constants: start bit 0, stop bit 1.
  - Default TICK_DIV and OVERSAMPLE.
  - Width helper for the divider counter.
- Sub-module uart_tick_gen:
  - Ports: sysclk, resetb, clr, tick.
  - Parameter: TICK_DIV.
  - Reused later by the RX side.

Test Plan:
- Reset and single byte: TICK_DIV=4, reset then req0=1 with data0=8'hA5.
  - ack0 pulses 1 cycle; tx = 0,1,0,1,0,0,1,0,1,1, each level held 64 cycles.
  - busy high for exactly 640 cycles; grant_id=0.
- Tie arbitration: both reqs high from reset (data0=8'h11, data1=8'h22), each dropped after its ack.
  - Port 0 is sent first, then port 1.
  - Exactly one tx-high cycle between the first stop bit and the second start bit.
- Fairness: both reqs held high for 4 frames.
  - ack order is 0,1,0,1; grant_id tracks each frame.
- Mid-frame interference: req1 asserted and data0 changed to 8'hFF during port 0's DATA state.
  - Serialised byte stays 8'hA5.
  - ack1 is not asserted until the cycle after busy falls.
- Reset mid-frame: resetb pulled low during bit 3 of the data bits.
  - tx=1 and busy=0 immediately, with no clock edge needed.
  - After release, the next req0 produces a full, correct frame.
- Single requester held: req1 held high alone for 2 frames.
  - Two frames are sent with ack1 pulses 641 cycles apart (TICK_DIV=4).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame bit levels, default timing
// parameters and a counter width helper used by the TX arbiter and tick generator.
package uart_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_START = 2'd1;
    localparam state_t ST_DATA  = 2'd2;
    localparam state_t ST_STOP  = 2'd3;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int DEF_TICK_DIV   = 328;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_DATA_W     = 8;

    // Bits needed for a counter running 0..n-1 (never narrower than one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick generator: one-cycle enable every TICK_DIV sysclk cycles,
// synchronously restartable so a frame can begin on an exact tick boundary.
module uart_tick_gen
    import uart_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic sysclk,
    input  logic resetb,
    input  logic clr,
    output logic tick
);

    localparam int CW = cnt_width(TICK_DIV);
    localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == TERM);
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge sysclk or negedge resetb) begin
        if (!resetb) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-port round-robin arbiter feeding a single 8N1 UART transmitter; the granted
// byte is latched at grant time so requesters may change data during the frame.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int DATA_W     = DEF_DATA_W
) (
    input  logic              sysclk,
    input  logic              resetb,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    output logic              ack0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              ack1,
    output logic              tx,
    output logic              busy,
    output logic              grant_id
);

    localparam int TW = cnt_width(OVERSAMPLE);
    localparam int BW = cnt_width(DATA_W);
    localparam logic [TW-1:0] TCNT_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [BW-1:0]     bit_idx_q, bit_idx_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;

    logic tick;
    logic tick_clr;
    logic bit_end;
    logic pick;

    uart_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .sysclk(sysclk),
        .resetb(resetb),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        tcnt_d    = tcnt_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        grant_d   = grant_q;
        last_d    = last_q;
        tick_clr  = 1'b0;
        pick      = 1'b0;
        bit_end   = tick && (tcnt_q == TCNT_LAST);

        if (tick && (state_q != ST_IDLE)) begin
            tcnt_d = (tcnt_q == TCNT_LAST) ? '0 : tcnt_q + TW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    // On a tie the port that did not own the previous frame wins.
                    pick      = (req0 && req1) ? ~last_q : req1;
                    ack0_d    = ~pick;
                    ack1_d    = pick;
                    shift_d   = pick ? data1 : data0;
                    grant_d   = pick;
                    last_d    = pick;
                    tx_d      = START_BIT;
                    busy_d    = 1'b1;
                    state_d   = ST_START;
                    tick_clr  = 1'b1;
                    tcnt_d    = '0;
                    bit_idx_d = '0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    tx_d      = shift_q[0];
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = ST_STOP;
                        tx_d    = STOP_BIT;
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + BW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge resetb) begin
        if (!resetb) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            tcnt_q    <= '0;
            bit_idx_q <= '0;
            tx_q      <= STOP_BIT;
            busy_q    <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            tcnt_q    <= tcnt_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign grant_id = grant_q;

endmodule
